noc_leaf_injector: RTL and testbench

- Clocked network-interface transmitter that feeds a leaf input port of the asynchronous tree router.
- Accepts words with a tail marker from a synchronous host over a valid/ready interface and buffers them in a small FIFO.
- Serializes each buffered word into one dual-rail (1-of-2 per bit) flit on a 4-phase return-to-zero handshake, paced by the receiver's enable.
- It is the sending end of the e1of2 flit channel consumed by the router's leaf decoders.

---
 rtl/noc_leaf_injector.sv | 132 +++++++++++++
 tb/tb_noc_leaf_injector.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_leaf_injector.sv
// Clocked leaf transmitter: buffers host words in a small FIFO and sends each one
// as a dual-rail flit on a 4-phase return-to-zero handshake paced by Out_e.
module noc_leaf_injector #(
  parameter int WIDTH       = 9,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             _RESET,
  input  logic             in_valid,
  input  logic [WIDTH-2:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] Out_d0,
  output logic [WIDTH-1:0] Out_d1,
  input  logic             Out_e,
  output logic             busy,
  output logic [CNT_W-1:0] flit_count,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, RTZ = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            count_q, count_d;
  logic                   in_ready_q, in_ready_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]       d0_q, d0_d, d1_q, d1_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       flit_cnt_q, flit_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic                   e_s, push, pop;

  // Host handshake: a word transfers on a CLK edge where in_valid && in_ready;
  // in_valid may be raised without waiting for in_ready, and in_ready is registered.
  assign push = in_valid && in_ready_q;
  assign e_s  = sync_q[SYNC_STAGES-1];
  assign pop  = (state_q == IDLE) && (count_q != '0) && e_s;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], Out_e};
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    // Registered from the next count, so a pop while full reopens in_ready one cycle later.
    in_ready_d = (count_d < FULL_CNT);
  end

  always_comb begin
    state_d    = state_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          d1_d    = mem_q[rd_ptr_q];
          d0_d    = ~mem_q[rd_ptr_q];
          state_d = DATA;
        end
      end
      DATA: begin
        if (!e_s) begin
          d0_d       = '0;
          d1_d       = '0;
          flit_cnt_d = flit_cnt_q + CNT_W'(1);
          if (d1_q[WIDTH-1]) pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          state_d    = RTZ;
        end
      end
      RTZ: begin
        if (e_s) state_d = IDLE;
      end
      default: begin
        d0_d    = '0;
        d1_d    = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (count_d != '0) || (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      sync_q     <= '1;
      d0_q       <= '0;
      d1_q       <= '0;
      busy_q     <= 1'b0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      sync_q     <= sync_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      busy_q     <= busy_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  // Storage needs no reset: pointer reset alone discards buffered words.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end

  assign in_ready   = in_ready_q;
  assign Out_d0     = d0_q;
  assign Out_d1     = d1_q;
  assign busy       = busy_q;
  assign flit_count = flit_cnt_q;
  assign pkt_count  = pkt_cnt_q;
endmodule

// File: tb/tb_noc_leaf_injector.sv
// Bench for noc_leaf_injector: reactive dual-rail receiver, expected-token queue,
// vector table, hand-written corner sequences and randomized traffic.
module tb_noc_leaf_injector;
  localparam int WIDTH = 9;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam logic [31:0] CNT_MASK = (32'd1 << CNT_W) - 32'd1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic [WIDTH-2:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_e = 1'b1;
  logic             in_ready, busy;
  logic [WIDTH-1:0] out_d0, out_d1;
  logic [CNT_W-1:0] flit_count, pkt_count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];
  int               mdl_flits = 0;
  int               mdl_pkts = 0;

  typedef enum int {RX_WAIT, RX_FALL, RX_NULL, RX_RISE} rx_e;
  rx_e              rx_st = RX_WAIT;
  int               rx_cnt = 0;
  int               rx_fall_dly = 2;
  int               rx_rise_dly = 2;
  bit               rx_stall = 1'b0;
  bit               rx_rand = 1'b0;
  logic [WIDTH-1:0] tok_d1 = '0;
  logic [WIDTH-1:0] tok_d0 = '0;
  logic [WIDTH-1:0] inv_d1;

  typedef struct {
    logic [WIDTH-2:0] data;
    logic             last;
    logic [WIDTH-1:0] exp_d1;
    logic [WIDTH-1:0] exp_d0;
  } vec_t;
  vec_t vecs[6];

  noc_leaf_injector #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .CNT_W(CNT_W)
  ) dut (
    .CLK(clk), ._RESET(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .Out_d0(out_d0), .Out_d1(out_d1),
    .Out_e(out_e), .busy(busy), .flit_count(flit_count), .pkt_count(pkt_count)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s actual=0x%0h required=none t=%0t", name, act, $time);
  endtask

  // ---------------- receiver model (sole driver of out_e) ----------------
  initial begin : receiver
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        rx_st = RX_WAIT;
        out_e = 1'b1;
      end else begin
        case (rx_st)
          RX_WAIT: begin
            if (out_d0 !== '0 || out_d1 !== '0) begin
              inv_d1 = ~out_d1;
              check("rail_onehot", out_d0, inv_d1);
              if (exp_q.size() == 0) flag("unexpected_token", out_d1);
              else check("token_value", out_d1, exp_q.pop_front());
              tok_d1 = out_d1;
              tok_d0 = out_d0;
              rx_cnt = 0;
              rx_st  = RX_FALL;
            end
          end
          RX_FALL: begin
            check("rails_stable_d1", out_d1, tok_d1);
            check("rails_stable_d0", out_d0, tok_d0);
            if (!rx_stall) begin
              if (rx_cnt >= rx_fall_dly) begin
                out_e  = 1'b0;
                rx_cnt = 0;
                rx_st  = RX_NULL;
              end else rx_cnt++;
            end
          end
          RX_NULL: begin
            if (out_d1 === '0 && out_d0 === '0) begin
              mdl_flits++;
              if (tok_d1[WIDTH-1]) mdl_pkts++;
              check("flit_count", flit_count, 32'(mdl_flits) & CNT_MASK);
              check("pkt_count", pkt_count, 32'(mdl_pkts) & CNT_MASK);
              rx_cnt = 0;
              rx_st  = RX_RISE;
            end else begin
              check("rtz_hold_d1", out_d1, tok_d1);
              check("rtz_hold_d0", out_d0, tok_d0);
              rx_cnt++;
              if (rx_cnt > 20) begin
                flag("rtz_timeout", out_d1);
                rx_cnt = 0;
                rx_st  = RX_RISE;
              end
            end
          end
          RX_RISE: begin
            check("rails_null_rtz", {out_d1, out_d0}, 32'd0);
            if (rx_cnt >= rx_rise_dly) begin
              out_e = 1'b1;
              rx_st = RX_WAIT;
              if (rx_rand) begin
                rx_fall_dly = $urandom_range(0, 3);
                rx_rise_dly = $urandom_range(0, 3);
              end
            end else rx_cnt++;
          end
          default: rx_st = RX_WAIT;
        endcase
      end
    end
  end

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic push_word(input logic [WIDTH-2:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) flag("push_timeout", n);
    else exp_q.push_back({l, d});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || rx_st != RX_WAIT) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) flag("drain_timeout", exp_q.size());
    repeat (6) @(negedge clk);
    check("idle_busy", busy, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    vecs[0] = '{8'hA5, 1'b1, 9'h1A5, 9'h05A};
    vecs[1] = '{8'h00, 1'b0, 9'h000, 9'h1FF};
    vecs[2] = '{8'hFF, 1'b1, 9'h1FF, 9'h000};
    vecs[3] = '{8'h3C, 1'b0, 9'h03C, 9'h1C3};
    vecs[4] = '{8'h81, 1'b1, 9'h181, 9'h07E};
    vecs[5] = '{8'h5A, 1'b0, 9'h05A, 9'h1A5};

    // Reset values, then in_ready low for exactly one cycle after release
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_d0", out_d0, 32'd0);
    check("rst_d1", out_d1, 32'd0);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_flit_count", flit_count, 32'd0);
    check("rst_pkt_count", pkt_count, 32'd0);
    #2 rst_n = 1'b1;
    #1 check("rel_in_ready_first", in_ready, 32'd0);
    @(negedge clk);
    check("rel_in_ready_next", in_ready, 32'd1);

    // Vector table of single flits (receiver: fall 2 after valid, rise 2 after null)
    for (int i = 0; i < 6; i++) begin
      push_word(vecs[i].data, vecs[i].last);
      wait_drain();
      check("vec_d1", tok_d1, vecs[i].exp_d1);
      check("vec_d0", tok_d0, vecs[i].exp_d0);
    end
    check("tbl_flit_count", flit_count, 32'd6);
    check("tbl_pkt_count", pkt_count, 32'd3);

    // 3-flit packet, one token at a time in order
    rx_fall_dly = 0;
    rx_rise_dly = 0;
    push_word(8'h01, 1'b0);
    push_word(8'h02, 1'b0);
    push_word(8'h03, 1'b1);
    wait_drain();
    check("pkt3_flit_count", flit_count, 32'd9);
    check("pkt3_pkt_count", pkt_count, 32'd4);

    // Backpressure: receiver stalls on the first token while 6 words are offered
    rx_fall_dly = 2;
    rx_rise_dly = 2;
    rx_stall = 1'b1;
    for (int i = 0; i < 5; i++) push_word(8'(8'h11 + i), 1'b0);
    repeat (2) @(negedge clk);
    check("bp_in_ready_low", in_ready, 32'd0);
    check("bp_token_held", out_d1, 32'h011);
    check("bp_busy", busy, 32'd1);
    in_valid = 1'b1;
    in_data  = 8'h16;
    in_last  = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_still_full", in_ready, 32'd0);
    rx_stall = 1'b0;
    push_word(8'h16, 1'b1);
    wait_drain();
    check("bp_flit_count", flit_count, 32'd15);
    check("bp_pkt_count", pkt_count, 32'd5);

    // Randomized traffic with random receiver pacing
    rx_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      push_word(8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_drain();
    rx_rand     = 1'b0;
    rx_fall_dly = 2;
    rx_rise_dly = 2;

    // Reset while a token is on the rails and two words are buffered
    rx_stall = 1'b1;
    push_word(8'h21, 1'b0);
    push_word(8'h22, 1'b0);
    push_word(8'h23, 1'b1);
    repeat (2) @(negedge clk);
    check("mid_token", out_d1, 32'h021);
    check("mid_busy", busy, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_d0", out_d0, 32'd0);
    check("mid_rst_d1", out_d1, 32'd0);
    check("mid_rst_busy", busy, 32'd0);
    check("mid_rst_in_ready", in_ready, 32'd0);
    exp_q.delete();
    mdl_flits = 0;
    mdl_pkts  = 0;
    rx_stall  = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_busy", busy, 32'd0);
    check("post_rst_flit_count", flit_count, 32'd0);

    // Counter wrap: 17 single-flit packets on a 4-bit counter
    rx_fall_dly = 0;
    rx_rise_dly = 0;
    for (int i = 0; i < 17; i++) push_word(8'($urandom_range(0, 255)), 1'b1);
    wait_drain();
    check("wrap_flit_count", flit_count, 32'd1);
    check("wrap_pkt_count", pkt_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
